// File: rtl/fir_frame_seq_pkg.sv
// Shared types for the vertical-FIR frame sequencer: FSM state encoding and flush sizing.
// Optional trailing flush phase is enabled by defining FIR_SEQ_FLUSH_EN.
package fir_pkg;

  localparam int DEF_TAP_NUMS = 3;
  localparam int FLUSH_LINES  = (DEF_TAP_NUMS - 1) / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
`ifdef FIR_SEQ_FLUSH_EN
    ST_FLUSH = 3'd3,
`endif
    ST_DONE  = 3'd4
  } fir_seq_state_t;

  // Lines of padding needed to drain a symmetric vertical filter of 'taps' taps.
  function automatic int flush_lines(input int taps);
    return (taps - 1) / 2;
  endfunction

endpackage

// File: rtl/fir_frame_seq_if.sv
// Pixel stream in / line-buffer control out bundle between upstream source and the sequencer.
interface fir_frame_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  ce_o;
  logic [DATA_WIDTH-1:0] data_pixel_o;
  logic                  first_ln_o;
  logic                  rd_en_o;

  modport master (
    output in_valid_i, in_data_i,
    input  in_ready_o, ce_o, data_pixel_o, first_ln_o, rd_en_o
  );

  modport slave (
    input  in_valid_i, in_data_i,
    output in_ready_o, ce_o, data_pixel_o, first_ln_o, rd_en_o
  );
endinterface

// File: rtl/fir_frame_seq_cnt.sv
// Column/row position counter with wrap; exposes terminal flags for the current geometry.
module fir_seq_cnt #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [CNT_WIDTH-1:0] width_i,
  input  logic [CNT_WIDTH-1:0] lines_i,
  output logic                 col_last_o,
  output logic                 row_last_o
);

  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;

  assign col_last_o = (col_q == width_i - CNT_WIDTH'(1));
  assign row_last_o = (row_q == lines_i - CNT_WIDTH'(1));

  // Clear wins over increment so a phase change can restart counting on the same edge.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_last_o ? '0 : row_q + CNT_WIDTH'(1);
      end else begin
        col_d = col_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/fir_frame_seq.sv
// Frame sequencer feeding a vertical FIR line buffer: fill, run, optional flush, done pulse.
// Define FIR_SEQ_FLUSH_EN to append (TAP_NUMS-1)/2 zero lines after each frame.
module fir_frame_seq
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int TAP_NUMS   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cfg_width_i,
  input  logic [CNT_WIDTH-1:0] cfg_height_i,
  input  logic                 start_i,
  fir_frame_seq_if.slave       bus,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  if (TAP_NUMS < 3 || (TAP_NUMS % 2) == 0) begin : g_bad_taps
    $error("TAP_NUMS must be odd and at least 3");
  end

  fir_seq_state_t       state_q;
  logic [CNT_WIDTH-1:0] width_q, height_q;
  logic                 in_ready_q, first_ln_q, rd_en_q, busy_q, done_q, flush_q;

  logic                  start_ok, accept, frame_end, col_last, row_last;
  logic                  cnt_clr, cnt_inc;
  logic [CNT_WIDTH-1:0]  lines_mux;
  logic [DATA_WIDTH-1:0] pix_d;

  assign start_ok  = start_i && (cfg_width_i != '0) && (cfg_height_i != '0);
  assign accept    = bus.in_valid_i & in_ready_q;
  assign frame_end = accept & col_last & row_last;

`ifdef FIR_SEQ_FLUSH_EN
  localparam int FLUSH_N = flush_lines(TAP_NUMS);

  // The counter is reused during flush, measuring zero lines instead of frame rows.
  assign cnt_clr   = ((state_q == ST_IDLE) && start_ok) || frame_end;
  assign cnt_inc   = accept | flush_q;
  assign lines_mux = flush_q ? CNT_WIDTH'(FLUSH_N) : height_q;
  assign bus.ce_o  = accept | flush_q;
`else
  assign cnt_clr   = (state_q == ST_IDLE) && start_ok;
  assign cnt_inc   = accept;
  assign lines_mux = height_q;
  assign bus.ce_o  = accept;
`endif

  assign pix_d            = in_ready_q ? bus.in_data_i : '0;
  assign bus.data_pixel_o = pix_d;
  assign bus.in_ready_o   = in_ready_q;
  assign bus.first_ln_o   = first_ln_q;
  assign bus.rd_en_o      = rd_en_q;
  assign busy_o           = busy_q;
  assign frame_done_o     = done_q;

  fir_seq_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .width_i    (width_q),
    .lines_i    (lines_mux),
    .col_last_o (col_last),
    .row_last_o (row_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      in_ready_q <= 1'b0;
      first_ln_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            width_q    <= cfg_width_i;
            height_q   <= cfg_height_i;
            state_q    <= ST_FILL;
            in_ready_q <= 1'b1;
            first_ln_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_FILL, ST_RUN: begin
          if (accept && col_last) begin
            first_ln_q <= 1'b0;
            if (row_last) begin
              in_ready_q <= 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
              state_q    <= ST_FLUSH;
              rd_en_q    <= 1'b1;
              flush_q    <= 1'b1;
`else
              state_q    <= ST_DONE;
              rd_en_q    <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              state_q <= ST_RUN;
              rd_en_q <= 1'b1;
            end
          end
        end
`ifdef FIR_SEQ_FLUSH_EN
        ST_FLUSH: begin
          if (col_last && row_last) begin
            state_q <= ST_DONE;
            flush_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_frame_seq.md
FIR_FRAME_SEQ -- requirements
Module: fir_frame_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter CNT_WIDTH, default 12, column/row counter width.
REQ-003 SHALL have parameter TAP_NUMS, default 3, vertical taps; odd, >=3.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_width_i, input, CNT_WIDTH, pixels per line.
REQ-007 SHALL have port cfg_height_i, input, CNT_WIDTH, lines per frame.
REQ-008 SHALL have port start_i, input, 1, frame start pulse.
REQ-009 SHALL have ports in_valid_i (input, 1) and in_data_i (input, DATA_WIDTH), pixel stream.
REQ-010 SHALL have port in_ready_o, output, 1, stream accept.
REQ-011 SHALL have ports ce_o (output, 1) and data_pixel_o (output, DATA_WIDTH), line-buffer pixel strobe/data.
REQ-012 SHALL have ports first_ln_o (output, 1), rd_en_o (output, 1), line-buffer control.
REQ-013 SHALL have ports busy_o (output, 1) and frame_done_o (output, 1, one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE, FILL, RUN, FLUSH, DONE; registered state.
REQ-015 IDLE: start_i with cfg_width_i!=0 and cfg_height_i!=0 SHALL latch both configs, clear col/row counters, go FILL; otherwise start_i ignored.
REQ-016 cfg_* changes outside IDLE SHALL have no effect.
REQ-017 in_ready_o SHALL be 1 only in FILL and RUN; accept = in_valid_i & in_ready_o.
REQ-018 FILL/RUN: ce_o = accept, data_pixel_o = in_data_i (combinational, zero latency).
REQ-019 Each accept SHALL increment col_cnt; at col_cnt==width-1 wrap to 0 and increment row_cnt.
REQ-020 first_ln_o SHALL be 1 exactly while row_cnt==0 (FILL); FILL->RUN at that wrap.
REQ-021 rd_en_o SHALL be 1 in RUN and FLUSH, 0 elsewhere.
REQ-022 Last accept of row height-1 SHALL go to FLUSH (macro on) or DONE (macro off).
REQ-023 height==1: last accept of row 0 SHALL leave FILL directly for FLUSH/DONE.
REQ-024 DONE SHALL last one cycle with frame_done_o=1, then IDLE.
REQ-025 busy_o SHALL be 1 in all states except IDLE.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 in_valid_i high in IDLE/FLUSH/DONE SHALL not be accepted nor counted.

Reset
REQ-028 rst_n low SHALL force IDLE, counters and latched cfg to 0, all outputs 0, at any time incl. mid-frame.
REQ-029 After reset release, first action SHALL require a new start_i.

Configuration
REQ-030 Macro FIR_SEQ_FLUSH_EN defined: FLUSH emits (TAP_NUMS-1)/2 lines of width ce_o pulses, one per cycle, data_pixel_o=0, first_ln_o=0, then DONE.
REQ-031 FIR_SEQ_FLUSH_EN undefined: FLUSH state absent; RUN/FILL go to DONE; no extra ce_o.

Structure
REQ-032 Package fir_pkg SHALL hold state enum fir_seq_state_t and constant FLUSH_LINES=(TAP_NUMS-1)/2.
REQ-033 Sub-module fir_seq_cnt (col/row counter with wrap and terminal flags) SHALL be instantiated once.

Verification
REQ-034 width=4, height=3, valid always 1 -> 12 ce_o in 12 cycles, first_ln_o on first 4, flush 4 ce_o of 0 (macro on), frame_done_o at cycle 17.
REQ-035 Same frame, in_valid_i toggled 1/0 -> 12 ce_o over 24 cycles, counts unaffected by gaps.
REQ-036 start_i with width=0 -> busy_o stays 0, no frame_done_o.
REQ-037 height=1, width=2 -> 2 ce_o with first_ln_o=1, rd_en_o never 1 before FLUSH.
REQ-038 rst_n low at row 1 col 2 -> all outputs 0 next edge; new start_i restarts at row 0, first_ln_o=1.
REQ-039 Macro off, width=4, height=3 -> frame_done_o right after 12th ce_o, no zero pixels.
